// File: rtl/ram_burst_ctrl.sv
// Stream-to-burst adapter for a 512x32 burst RAM: gathers/drains word streams in 16-word chunks.
// Optional address range checking and clamping is enabled with `define RAM_BURST_ADDR_CHECK_EN.
module ram_burst_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int BURST  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [5:0]                 cmd_len,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_last,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [$clog2(BURST)-1:0]   ram_cnt,
  output logic [DATA_W*BURST-1:0]    ram_wdata,
  input  logic [DATA_W*BURST-1:0]    ram_rdata
);

  localparam int CNT_W = $clog2(BURST);
  localparam int CW    = CNT_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WFILL  = 3'd1;
  localparam logic [2:0] S_WBURST = 3'd2;
  localparam logic [2:0] S_RISSUE = 3'd3;
  localparam logic [2:0] S_RWAIT  = 3'd4;
  localparam logic [2:0] S_RDRAIN = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_cur_addr;
  logic [6:0]        r_remaining;
  logic [CNT_W-1:0]  r_idx;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [CNT_W-1:0]  r_ram_cnt;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_buf       [BURST];
  logic [DATA_W-1:0] r_ram_wdata [BURST];

  logic [DATA_W-1:0] w_rdata [BURST];
  logic [CW-1:0]     w_chunk, w_next_chunk, w_cmd_chunk;
  logic [CW-1:0]     w_inrange, w_next_inrange, w_cmd_inrange;
  logic [ADDR_W:0]   w_next_addr;
  logic [6:0]        w_next_rem, w_cmd_rem;
  logic              w_cmd_oor;
  logic              w_chunk_end;
  logic              w_wr_hs, w_wr_last;

  function automatic logic [CW-1:0] f_chunk(input logic [6:0] rem);
    return (rem > 7'(BURST)) ? CW'(BURST) : rem[CW-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] f_cnt(input logic [CW-1:0] n);
    return (n == '0) ? '0 : CNT_W'(n - 1'b1);
  endfunction

  assign w_cmd_rem    = 7'(cmd_len) + 7'd1;
  assign w_cmd_chunk  = f_chunk(w_cmd_rem);
  assign w_chunk      = f_chunk(r_remaining);
  assign w_next_addr  = r_cur_addr + (ADDR_W+1)'(w_chunk);
  assign w_next_rem   = r_remaining - 7'(w_chunk);
  assign w_next_chunk = f_chunk(w_next_rem);

`ifdef RAM_BURST_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // Number of words of a chunk that land inside the RAM; 0 means skip the access.
  function automatic logic [CW-1:0] f_inrange(input logic [ADDR_W:0] addr, input logic [CW-1:0] chunk);
    logic [ADDR_W:0] room;
    room = DEPTH - addr;
    if (addr >= DEPTH) return '0;
    if (room < (ADDR_W+1)'(chunk)) return CW'(room);
    return chunk;
  endfunction

  assign w_inrange      = f_inrange(r_cur_addr, w_chunk);
  assign w_next_inrange = f_inrange(w_next_addr, w_next_chunk);
  assign w_cmd_inrange  = f_inrange({1'b0, cmd_addr}, w_cmd_chunk);
  assign w_cmd_oor      = (({1'b0, cmd_addr} + (ADDR_W+1)'(cmd_len)) > (DEPTH - 1'b1));
`else
  assign w_inrange      = w_chunk;
  assign w_next_inrange = w_next_chunk;
  assign w_cmd_inrange  = w_cmd_chunk;
  assign w_cmd_oor      = 1'b0;
`endif

  assign w_chunk_end = ({1'b0, r_idx} == w_chunk - 1'b1);
  assign w_wr_hs     = (r_state == S_WFILL) && wr_valid;
  assign w_wr_last   = w_wr_hs && w_chunk_end;

  generate
    for (genvar gi = 0; gi < BURST; gi++) begin : g_word
      assign w_rdata[gi] = ram_rdata[gi*DATA_W +: DATA_W];
      assign ram_wdata[gi*DATA_W +: DATA_W] = r_ram_wdata[gi];

      // Out-of-range slots are zeroed at capture so the drain path needs no masking.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_buf[gi]       <= '0;
          r_ram_wdata[gi] <= '0;
        end else begin
          if (w_wr_hs && (r_idx == CNT_W'(gi)))
            r_buf[gi] <= wr_data;
          else if (r_state == S_RWAIT)
            r_buf[gi] <= (CW'(gi) < w_inrange) ? w_rdata[gi] : '0;
          if (w_wr_last)
            r_ram_wdata[gi] <= (r_idx == CNT_W'(gi)) ? wr_data : r_buf[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_idx       <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_cnt   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_ram_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_cur_addr  <= {1'b0, cmd_addr};
            r_remaining <= w_cmd_rem;
            r_idx       <= '0;
            r_err       <= w_cmd_oor;
            if (cmd_we) begin
              r_state <= S_WFILL;
            end else begin
              r_state    <= S_RISSUE;
              r_ram_addr <= cmd_addr;
              r_ram_cnt  <= f_cnt(w_cmd_inrange);
            end
          end
        end
        S_WFILL: begin
          if (w_wr_last) begin
            r_state    <= S_WBURST;
            r_ram_we   <= (w_inrange != '0);
            r_ram_addr <= r_cur_addr[ADDR_W-1:0];
            r_ram_cnt  <= f_cnt(w_inrange);
            r_idx      <= '0;
          end else if (w_wr_hs) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_WBURST: begin
          r_cur_addr  <= w_next_addr;
          r_remaining <= w_next_rem;
          if (w_next_rem != '0) begin
            r_state <= S_WFILL;
          end else begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        S_RISSUE: r_state <= S_RWAIT;
        S_RWAIT: begin
          r_state <= S_RDRAIN;
          r_idx   <= '0;
        end
        S_RDRAIN: begin
          if (rd_ready) begin
            if (w_chunk_end) begin
              r_idx       <= '0;
              r_cur_addr  <= w_next_addr;
              r_remaining <= w_next_rem;
              if (w_next_rem != '0) begin
                r_state    <= S_RISSUE;
                r_ram_addr <= w_next_addr[ADDR_W-1:0];
                r_ram_cnt  <= f_cnt(w_next_inrange);
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign wr_ready  = (r_state == S_WFILL);
  assign rd_valid  = (r_state == S_RDRAIN);
  assign rd_data   = r_buf[r_idx];
  assign rd_last   = (r_state == S_RDRAIN) && w_chunk_end && (r_remaining == 7'(w_chunk));
  assign done      = r_done;
  assign err       = r_err;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_cnt   = r_ram_cnt;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomized bench for ram_burst_ctrl with a behavioural 512x32 burst RAM and a word-level memory model.
module tb_ram_burst_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_we;
  logic [8:0]   cmd_addr;
  logic [5:0]   cmd_len;
  logic         wr_valid, wr_ready;
  logic [31:0]  wr_data;
  logic         rd_valid, rd_ready, rd_last;
  logic [31:0]  rd_data;
  logic         busy, done, err;
  logic         ram_we;
  logic [8:0]   ram_addr;
  logic [3:0]   ram_cnt;
  logic [511:0] ram_wdata;
  logic [511:0] ram_rdata;

  ram_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done), .err(err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_cnt(ram_cnt),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] tb_mem  [512];
  logic [31:0] ref_mem [512];
  logic [31:0] wq      [64];
  int          exp_baddr [$];
  int          exp_bcnt  [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Burst RAM: commits on the negedge of the we cycle, registered read outputs.
  always @(negedge clk) begin
    if (ram_we)
      for (int i = 0; i < 16; i++)
        if (i <= int'(ram_cnt) && int'(ram_addr) + i < 512)
          tb_mem[int'(ram_addr) + i] <= ram_wdata[i*32 +: 32];
  end

  // DEADBEEF stands in for the RAM's undriven out-of-range outputs.
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (i > int'(ram_cnt))
        ram_rdata[i*32 +: 32] <= 32'h0;
      else if (int'(ram_addr) + i > 511)
        ram_rdata[i*32 +: 32] <= 32'hDEADBEEF;
      else
        ram_rdata[i*32 +: 32] <= tb_mem[int'(ram_addr) + i];
    end
  end

  always @(negedge clk) begin
    if (!rst && ram_we) begin
      if (exp_baddr.size() == 0) begin
        chk("burst_unexpected", 32'(ram_we), 32'h0);
      end else begin
        chk("burst_addr", 32'(ram_addr), 32'(exp_baddr.pop_front()));
        chk("burst_cnt", 32'(ram_cnt), 32'(exp_bcnt.pop_front()));
      end
    end
  end

  function automatic int exp_inrange(input int a, input int c);
`ifdef RAM_BURST_ADDR_CHECK_EN
    if (a > 511) return 0;
    if (512 - a < c) return 512 - a;
`endif
    return c;
  endfunction

  function automatic logic [31:0] exp_word(input int a);
    if (a > 511) return 32'h0;
    return ref_mem[a];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input int addr, input int len, input bit keep);
    int  cyc;
    logic exp_err;
    exp_err = 1'b0;
`ifdef RAM_BURST_ADDR_CHECK_EN
    exp_err = (addr + len > 511);
`endif
    cmd_we    = we;
    cmd_addr  = 9'(addr);
    cmd_len   = 6'(len);
    cmd_valid = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 200) begin
      step();
      cyc++;
    end
    chk("cmd_ready", 32'(cmd_ready), 32'h1);
    step();
    if (!keep) cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'h1);
    chk("err", 32'(err), 32'(exp_err));
    $display("cmd we=%0d addr=0x%03h len=%0d words=%0d", we, addr, len, len + 1);
  endtask

  task automatic feed_write(input int addr, input int n, input int limit);
    int cyc, s, c, inr;
    for (int k = 0; k < limit; k++) begin
      if (k > 0 && $urandom_range(3, 0) == 0) begin
        wr_valid = 1'b0;
        step();
      end
      s = (k / 16) * 16;
      c = (n - s < 16) ? n - s : 16;
      if (k == s + c - 1) begin
        inr = exp_inrange(addr + s, c);
        if (inr > 0) begin
          exp_baddr.push_back(addr + s);
          exp_bcnt.push_back(inr - 1);
        end
        for (int j = 0; j < c; j++)
          if (addr + s + j < 512) ref_mem[addr + s + j] = wq[s + j];
      end
      wr_valid = 1'b1;
      wr_data  = wq[k];
      cyc = 0;
      while (!wr_ready && cyc < 50) begin
        step();
        cyc++;
      end
      chk("wr_ready", 32'(wr_ready), 32'h1);
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic drain_read(input int addr, input int n, input int mode);
    int  k, cyc;
    bit  first;
    k = 0;
    cyc = 0;
    first = 1'b1;
    while (k < n && cyc < 2000) begin
      case (mode)
        1:       rd_ready = 1'($urandom_range(1, 0));
        2:       rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rd_ready = 1'b1;
      endcase
      chk("cmd_ready_busy", 32'(cmd_ready), 32'h0);
      if (rd_valid) begin
        if (first) chk("rd_latency", 32'(cyc + 1), 32'd3);
        first = 1'b0;
        chk("rd_data", rd_data, exp_word(addr + k));
        chk("rd_last", 32'(rd_last), 32'(k == n - 1));
        if (rd_ready) k++;
      end
      step();
      cyc++;
    end
    chk("rd_words", 32'(k), 32'(n));
    rd_ready = 1'b0;
  endtask

  task automatic wait_done(input bit hold);
    int cyc;
    cyc = 0;
    while (!done && cyc < 50) begin
      step();
      cyc++;
    end
    chk("done", 32'(done), 32'h1);
    if (hold) chk("cmd_ready_at_done", 32'(cmd_ready), 32'h1);
    step();
    if (hold) begin
      cmd_valid = 1'b0;
      chk("second_accept", 32'(busy), 32'h1);
    end
    chk("done_pulse", 32'(done), 32'h0);
  endtask

  task automatic do_write(input int addr, input int len);
    send_cmd(1'b1, addr, len, 1'b0);
    feed_write(addr, len + 1, len + 1);
    wait_done(1'b0);
  endtask

  task automatic do_read(input int addr, input int len, input int mode);
    send_cmd(1'b0, addr, len, 1'b0);
    drain_read(addr, len + 1, mode);
    wait_done(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int len, addr;
    for (int i = 0; i < 512; i++) begin
      tb_mem[i]  = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    step(); step(); step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_cnt", 32'(ram_cnt), 32'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) wq[i] = 32'hA0 + 32'(i);
    do_write(12'h010, 3);
    do_read(12'h010, 3, 0);

    for (int i = 0; i < 40; i++) wq[i] = $urandom;
    do_write(12'h100, 39);
    do_read(12'h100, 39, 1);
    do_read(12'h100, 15, 2);

`ifdef RAM_BURST_ADDR_CHECK_EN
    for (int i = 0; i < 8; i++) wq[i] = 32'hC0DE0000 + 32'(i);
    do_write(12'h1FC, 7);
    do_read(12'h1FC, 7, 2);
`endif

    for (int i = 0; i < 16; i++) wq[i] = $urandom;
    send_cmd(1'b1, 12'h040, 15, 1'b0);
    feed_write(12'h040, 16, 5);
    rst = 1'b1;
    step();
    chk("mrst_ram_we", 32'(ram_we), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_wr_ready", 32'(wr_ready), 32'h0);
    chk("mrst_rd_valid", 32'(rd_valid), 32'h0);
    chk("mrst_done", 32'(done), 32'h0);
    chk("mrst_err", 32'(err), 32'h0);
    chk("mrst_ram_addr", 32'(ram_addr), 32'h0);
    chk("mrst_ram_cnt", 32'(ram_cnt), 32'h0);
    chk("mrst_ram_wdata", 32'(|ram_wdata), 32'h0);
    rst = 1'b0;
    step();
    chk("mrst_cmd_ready", 32'(cmd_ready), 32'h1);
    do_read(12'h040, 15, 0);
    for (int i = 0; i < 16; i++) wq[i] = $urandom;
    do_write(12'h040, 15);
    do_read(12'h040, 15, 1);

    send_cmd(1'b0, 12'h100, 15, 1'b1);
    drain_read(12'h100, 16, 2);
    wait_done(1'b1);
    drain_read(12'h100, 16, 0);
    wait_done(1'b0);

    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(63, 0);
`ifdef RAM_BURST_ADDR_CHECK_EN
      addr = $urandom_range(511, 0);
`else
      addr = $urandom_range(511 - len, 0);
`endif
      if ($urandom_range(1, 0) == 1) begin
        for (int i = 0; i <= len; i++) wq[i] = $urandom;
        do_write(addr, len);
      end else begin
        do_read(addr, len, $urandom_range(2, 0));
      end
    end

    step(); step();
    chk("burst_q_empty", 32'(exp_baddr.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Stream-to-burst adapter that sits directly upstream of the 512x32 burst RAM (16-word data_in/data_out arrays, addr/cnt/we interface).
- Accepts a command (read or write, base address, length up to 64 words) over a valid/ready handshake.
- Writes: gathers a word-serial write stream into a 16-word buffer and issues single-cycle RAM write bursts.
- Reads: issues RAM read bursts, captures the 16-word result and drains it as a word-serial stream.

Parameters:
- DATA_W, 32, word width; must match the RAM word width.
- ADDR_W, 9, RAM address width (512 words).
- BURST, 16, maximum words per RAM burst; equals the RAM array port size.

Ports:
- clk  in  1  clock; all logic is posedge-clocked.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_we  in  1  1 = write command, 0 = read command.
- cmd_addr  in  ADDR_W  base word address.
- cmd_len  in  6  number of words minus 1 (1..64 words).
- wr_valid  in  1  write stream valid.
- wr_ready  out  1  write stream ready.
- wr_data  in  DATA_W  write word.
- rd_valid  out  1  read stream valid.
- rd_ready  in  1  read stream ready.
- rd_data  out  DATA_W  read word.
- rd_last  out  1  marks the final word of the command.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  sticky; set on an out-of-range command, cleared by the next command accept (see Optional Feature).
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_cnt  out  4  to RAM cnt (words minus 1).
- ram_wdata  out  DATA_W x BURST  to RAM data_in[0:15].
- ram_rdata  in  DATA_W x BURST  from RAM data_out[0:15].

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FSM goes to IDLE.
  - ram_we, rd_valid, rd_last, wr_ready, done, err, busy = 0.
  - ram_addr = 0, ram_cnt = 0; ram_wdata entries = 0.
  - Buffer contents and internal counters are cleared.
  - Reset mid-command abandons the command; no further RAM writes occur.
- RAM outputs are registered. ram_we is high for exactly one cycle per write burst and 0 otherwise.
- Command accept: cmd_valid && cmd_ready at a posedge.
  - Latches cmd_addr, cmd_len and cmd_we.
  - Sets remaining = cmd_len+1 and cur_addr = cmd_addr.
- Chunking:
  - chunk = min(remaining, BURST). Chunks are consecutive and ascending.
  - After each chunk: cur_addr += chunk, remaining -= chunk.
  - Address arithmetic is computed at ADDR_W+1 bits for the range check.
- FSM states: IDLE, WFILL, WBURST, RISSUE, RWAIT, RDRAIN.
- IDLE: cmd_ready = 1. On accept, go to WFILL (write) or RISSUE (read).
- WFILL:
  - wr_ready = 1.
  - Each wr_valid && wr_ready handshake stores wr_data into buffer[idx] and increments idx.
  - When idx reaches chunk: go to WBURST; wr_ready drops in the same cycle transition.
- WBURST (one cycle):
  - ram_we = 1, ram_addr = cur_addr, ram_cnt = chunk-1, ram_wdata = buffer.
  - The RAM commits the burst at this cycle's negedge.
  - Next state: WFILL if remaining > 0, else IDLE with done = 1.
- RISSUE (one cycle): ram_we = 0, ram_addr = cur_addr, ram_cnt = chunk-1. The RAM samples on the edge that ends this cycle.
- RWAIT (one cycle): RAM outputs are held. ram_rdata is captured into the buffer on the edge that ends this cycle.
- RDRAIN:
  - rd_valid = 1, rd_data = buffer[idx].
  - idx advances on each rd_valid && rd_ready.
  - rd_last = 1 on the final word of the whole command.
  - rd_valid and rd_data are held stable while rd_ready = 0.
  - After the final word of the chunk: go to RISSUE if remaining > 0, else IDLE with done = 1.
- Read latency: command accept to first rd_valid is 3 cycles.
- Write throughput: 1 word per cycle plus 1 WBURST cycle per chunk.
- wr_valid in any state other than WFILL is ignored; the stream is not consumed.
- cmd_valid while busy is not accepted.

Optional Feature:
- Macro: RAM_BURST_ADDR_CHECK_EN.
- Defined:
  - A command with cmd_addr + cmd_len > 511 sets err at accept; the command still runs.
  - ram_cnt is clamped so no burst word lies beyond address 511.
  - Write: words for out-of-range addresses are still consumed from the stream and discarded.
  - Read: out-of-range words return 32'h0 on rd_data.
  - A chunk lying entirely out of range skips the RAM access (no WBURST ram_we pulse) but keeps its stream timing.
- Undefined:
  - err is tied to 0 and no clamping is done.
  - The RAM's own out-of-range handling applies: writes are dropped, reads return Z.

Test Plan:
- Write cmd addr=0x010, len=3 (4 words 0xA0..0xA3), then read same range:
  - exactly one ram_we pulse, with ram_cnt=3;
  - rd_data sequence A0, A1, A2, A3, with rd_last on A3;
  - done pulses once per command.
- Write cmd addr=0x100, len=39 (40 words): three ram_we pulses with ram_cnt 15, 15, 7 at ram_addr 0x100, 0x110, 0x120. Readback matches.
- Read of 16 words with rd_ready toggling 1, 0, 0, 1: rd_data held stable while stalled; first rd_valid 3 cycles after accept.
- With RAM_BURST_ADDR_CHECK_EN, write addr=0x1FC, len=7 (8 words): err = 1, ram_cnt = 3, all 8 words consumed. Readback of the same command returns the 4 stored words then 0,0,0,0.
- Assert rst during WFILL after 5 of 16 words:
  - all outputs return to reset values;
  - no ram_we pulse occurs;
  - a subsequent command is accepted normally.
- cmd_valid held high during an active read: cmd_ready stays 0; the second command is accepted on the cycle after done.
